// File: rtl/tron_plot_arbiter.sv
// Round-robin plot arbiter for two tron players with a 1-bit occupancy bitmap and board-clear sweep.
// Latency: req sampled in IDLE -> ack/vga_plot 3 edges later, 4 cycles per transaction; requests wait (unacked) during a sweep.
module tron_plot_arbiter #(
    parameter int XW    = 8,
    parameter int YW    = 7,
    parameter int X_MAX = 160,
    parameter int Y_MAX = 120
) (
    input  logic          CLOCK_50,
    input  logic          resetn,
    input  logic          clear,
    input  logic          req_a,
    input  logic          req_b,
    input  logic [XW-1:0] x_a,
    input  logic [XW-1:0] x_b,
    input  logic [YW-1:0] y_a,
    input  logic [YW-1:0] y_b,
    input  logic [2:0]    colour_a,
    input  logic [2:0]    colour_b,
    output logic          ack_a,
    output logic          ack_b,
    output logic          dead_a,
    output logic          dead_b,
    output logic [XW-1:0] vga_x,
    output logic [YW-1:0] vga_y,
    output logic [2:0]    vga_colour,
    output logic          vga_plot,
    output logic          busy
);

    localparam int CELLS = X_MAX * Y_MAX;
    localparam int AW    = $clog2(CELLS);
    localparam logic [XW-1:0] X_LAST = XW'(X_MAX - 1);
    localparam logic [AW-1:0] A_LAST = AW'(CELLS - 1);

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_READ,
        ST_CHECK,
        ST_DONE
    } state_t;

    state_t        state;
    logic [XW-1:0] cx;
    logic [YW-1:0] cy;
    logic [AW-1:0] clr_addr;
    logic [XW-1:0] x_l;
    logic [YW-1:0] y_l;
    logic [2:0]    col_l;
    logic          id_l;
    logic          ptr;
    logic          clr_pend;

    logic          mem [0:CELLS-1];
    logic          rd_bit;
    logic          ram_we;
    logic          ram_wd;
    logic [AW-1:0] ram_wa;
    logic          ram_re;

    logic          in_range;
    logic          cell_free;
    logic          id_dead;
    logic          grant_b;
    logic [AW-1:0] lat_addr;

    assign in_range  = (32'(x_l) < X_MAX) && (32'(y_l) < Y_MAX);
    assign cell_free = in_range && !rd_bit;
    assign id_dead   = id_l ? dead_b : dead_a;
    assign grant_b   = req_b && (!req_a || ptr);
    assign lat_addr  = AW'(y_l) * AW'(X_MAX) + AW'(x_l);

    // Off-screen coordinates would alias onto valid cells, so they never touch the RAM.
    assign ram_re = resetn && (state == ST_READ) && in_range;

    always_comb begin
        ram_we = 1'b0;
        ram_wd = 1'b1;
        ram_wa = lat_addr;
        if (resetn) begin
            if (state == ST_CLEAR) begin
                ram_we = 1'b1;
                ram_wd = 1'b0;
                ram_wa = clr_addr;
            end else if (state == ST_CHECK && cell_free && !id_dead) begin
                ram_we = 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (ram_we)
            mem[ram_wa] <= ram_wd;
        if (ram_re)
            rd_bit <= mem[lat_addr];
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state      <= ST_CLEAR;
            cx         <= '0;
            cy         <= '0;
            clr_addr   <= '0;
            x_l        <= '0;
            y_l        <= '0;
            col_l      <= '0;
            id_l       <= 1'b0;
            ptr        <= 1'b0;
            clr_pend   <= 1'b0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
            ack_a      <= 1'b0;
            ack_b      <= 1'b0;
            dead_a     <= 1'b0;
            dead_b     <= 1'b0;
            busy       <= 1'b1;
        end else begin
            ack_a    <= 1'b0;
            ack_b    <= 1'b0;
            vga_plot <= 1'b0;
            if (state != ST_CLEAR && clear)
                clr_pend <= 1'b1;

            case (state)
                ST_CLEAR: begin
                    clr_pend   <= 1'b0;
                    vga_x      <= cx;
                    vga_y      <= cy;
                    vga_colour <= 3'b000;
                    vga_plot   <= 1'b1;
                    if (clr_addr == A_LAST) begin
                        cx       <= '0;
                        cy       <= '0;
                        clr_addr <= '0;
                        dead_a   <= 1'b0;
                        dead_b   <= 1'b0;
                        ptr      <= 1'b0;
                        busy     <= 1'b0;
                        state    <= ST_IDLE;
                    end else begin
                        clr_addr <= clr_addr + 1'b1;
                        if (cx == X_LAST) begin
                            cx <= '0;
                            cy <= cy + 1'b1;
                        end else begin
                            cx <= cx + 1'b1;
                        end
                    end
                end
                ST_IDLE: begin
                    if (clr_pend) begin
                        clr_pend <= 1'b0;
                        busy     <= 1'b1;
                        state    <= ST_CLEAR;
                    end else if (req_a || req_b) begin
                        x_l   <= grant_b ? x_b : x_a;
                        y_l   <= grant_b ? y_b : y_a;
                        col_l <= grant_b ? colour_b : colour_a;
                        id_l  <= grant_b;
                        ptr   <= !grant_b;
                        state <= ST_READ;
                    end
                end
                ST_READ: begin
                    state <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (!cell_free) begin
                        if (id_l)
                            dead_b <= 1'b1;
                        else
                            dead_a <= 1'b1;
                    end else if (!id_dead) begin
                        vga_x      <= x_l;
                        vga_y      <= y_l;
                        vga_colour <= col_l;
                        vga_plot   <= 1'b1;
                    end
                    ack_a <= !id_l;
                    ack_b <= id_l;
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_CLEAR;
                end
            endcase
        end
    end

endmodule
